// File: rtl/input_debounce_pkg.sv
// Shared types and helpers for the input_debounce block.
package input_debounce_pkg;

    // Per-channel filter state: output agrees with input, or a change is being timed.
    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } deb_state_e;

    // Counter width able to hold 0..cycles-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        int unsigned w;
        w = $clog2(cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/input_debounce_ch.sv
// Single-channel conditioner: 2-flop synchronizer, saturating-count
// debounce filter and one-cycle rise/fall pulse generation.
module debounce_ch
    import input_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    deb_state_e       state_q;
    deb_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             dout_d;
    logic             rise_d;
    logic             fall_d;
    logic             differ;
    logic             terminal;

    assign differ   = (sync2 != dout);
    assign terminal = (cnt_q == TERMINAL);

    // Two-flop synchronizer for the raw asynchronous level.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            dout    <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout    <= dout_d;
            rise    <= rise_d;
            fall    <= fall_d;
        end
    end

    // Next state and counter: count while the input disagrees, clear on revert or terminal count.
    // With DEBOUNCE_CYCLES=1 the terminal count is already reached in STABLE, so no PENDING visit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_STABLE: begin
                if (differ && !terminal) begin
                    state_d = ST_PENDING;
                    cnt_d   = cnt_q + CNT_W'(1);
                end else begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end
            end
            ST_PENDING: begin
                if (!differ || terminal) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_PENDING;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output level update and edge pulses on terminal count.
    always_comb begin
        dout_d = dout;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (differ && terminal) begin
            dout_d = sync2;
            rise_d = sync2;
            fall_d = ~sync2;
        end
    end

endmodule

// File: rtl/input_debounce.sv
// Multi-channel input conditioner: NUM_CH independent debounce_ch instances.
module input_debounce
    import input_debounce_pkg::*;
#(
    parameter int unsigned NUM_CH          = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] din,
    output logic [NUM_CH-1:0] dout,
    output logic [NUM_CH-1:0] rise,
    output logic [NUM_CH-1:0] fall
);

    localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_ch (
            .clock (clock),
            .reset (reset),
            .din   (din[i]),
            .dout  (dout[i]),
            .rise  (rise[i]),
            .fall  (fall[i])
        );
    end

endmodule

// File: tb/tb_input_debounce.sv
// Directed bench for input_debounce with NUM_CH=2, DEBOUNCE_CYCLES=4.
module tb_input_debounce;

    logic       clock;
    logic       reset;
    logic [1:0] din;
    logic [1:0] dout;
    logic [1:0] rise;
    logic [1:0] fall;

    int unsigned total;
    int unsigned bad;

    input_debounce #(
        .NUM_CH          (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .din   (din),
        .dout  (dout),
        .rise  (rise),
        .fall  (fall)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance past one rising edge and sample 1 time unit later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect3(input string tag, input logic [1:0] ed, input logic [1:0] er,
                           input logic [1:0] ef);
        total++;
        assert ({dout, rise, fall} === {ed, er, ef})
        else begin
            bad++;
            $error("FAIL %s dout/rise/fall=%b/%b/%b expected %b/%b/%b",
                   tag, dout, rise, fall, ed, er, ef);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        din   = 2'b11;

        // Reset held with din=11: everything stays 0.
        for (int i = 0; i < 3; i++) begin
            tick();
            expect3("reset_hold", 2'b00, 2'b00, 2'b00);
        end
        din   = 2'b00;
        reset = 1'b0;
        tick();
        tick();
        expect3("post_reset", 2'b00, 2'b00, 2'b00);

        // Clean step on din[0]: dout changes on the 6th edge after driving.
        din = 2'b01;
        for (int i = 0; i < 5; i++) begin
            tick();
            expect3("step_wait", 2'b00, 2'b00, 2'b00);
        end
        tick();
        expect3("step_rise", 2'b01, 2'b01, 2'b00);
        tick();
        expect3("step_hold", 2'b01, 2'b00, 2'b00);

        // 3-cycle glitch on din[1]: rejected.
        din = 2'b11;
        tick(); tick(); tick();
        din = 2'b01;
        for (int i = 0; i < 8; i++) begin
            tick();
            expect3("glitch3", 2'b01, 2'b00, 2'b00);
        end

        // 4-cycle pulse on din[1]: accepted, then released.
        din = 2'b11;
        for (int i = 0; i < 4; i++) begin
            tick();
            expect3("pulse4_wait", 2'b01, 2'b00, 2'b00);
        end
        din = 2'b01;
        tick();
        expect3("pulse4_wait5", 2'b01, 2'b00, 2'b00);
        tick();
        expect3("pulse4_rise", 2'b11, 2'b10, 2'b00);
        tick();
        expect3("pulse4_hi", 2'b11, 2'b00, 2'b00);
        tick();
        tick();
        expect3("pulse4_hi2", 2'b11, 2'b00, 2'b00);
        tick();
        expect3("pulse4_fall", 2'b01, 2'b00, 2'b10);
        tick();
        expect3("pulse4_lo", 2'b01, 2'b00, 2'b00);

        // Return din[0] to 0 before the bounce test.
        din = 2'b00;
        for (int i = 0; i < 5; i++) tick();
        expect3("ch0_pre_fall", 2'b01, 2'b00, 2'b00);
        tick();
        expect3("ch0_fall", 2'b00, 2'b00, 2'b01);
        tick();
        tick();
        expect3("ch0_low", 2'b00, 2'b00, 2'b00);

        // Bounce 1,0,1,0,1 then hold 1: single rise 6 edges after final drive.
        din = 2'b01; tick();
        din = 2'b00; tick();
        din = 2'b01; tick();
        din = 2'b00; tick();
        din = 2'b01;
        for (int i = 0; i < 5; i++) begin
            tick();
            expect3("bounce_wait", 2'b00, 2'b00, 2'b00);
        end
        tick();
        expect3("bounce_rise", 2'b01, 2'b01, 2'b00);
        tick();
        expect3("bounce_hold", 2'b01, 2'b00, 2'b00);

        // Back to 00 for the simultaneous test.
        din = 2'b00;
        for (int i = 0; i < 8; i++) tick();
        expect3("sim_pre", 2'b00, 2'b00, 2'b00);

        // Simultaneous rise on both channels.
        din = 2'b11;
        for (int i = 0; i < 5; i++) begin
            tick();
            expect3("sim_rise_wait", 2'b00, 2'b00, 2'b00);
        end
        tick();
        expect3("sim_rise", 2'b11, 2'b11, 2'b00);
        tick();
        expect3("sim_rise_hold", 2'b11, 2'b00, 2'b00);

        // Simultaneous fall on both channels.
        din = 2'b00;
        for (int i = 0; i < 5; i++) begin
            tick();
            expect3("sim_fall_wait", 2'b11, 2'b00, 2'b00);
        end
        tick();
        expect3("sim_fall", 2'b00, 2'b00, 2'b11);
        tick();
        expect3("sim_fall_hold", 2'b00, 2'b00, 2'b00);

        // Async reset mid-cycle while dout=11, din held 11 through release.
        din = 2'b11;
        for (int i = 0; i < 7; i++) tick();
        expect3("async_pre", 2'b11, 2'b00, 2'b00);
        #3;
        reset = 1'b1;
        #1;
        expect3("async_clear", 2'b00, 2'b00, 2'b00);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            expect3("async_rel_wait", 2'b00, 2'b00, 2'b00);
        end
        tick();
        expect3("async_rel_rise", 2'b11, 2'b11, 2'b00);

        // Reset mid-count on channel 0.
        din = 2'b00;
        for (int i = 0; i < 8; i++) tick();
        expect3("midcnt_pre", 2'b00, 2'b00, 2'b00);
        din = 2'b01;
        for (int i = 0; i < 4; i++) tick();
        expect3("midcnt_counting", 2'b00, 2'b00, 2'b00);
        reset = 1'b1;
        #1;
        expect3("midcnt_reset", 2'b00, 2'b00, 2'b00);
        tick();
        tick();
        expect3("midcnt_reset_hold", 2'b00, 2'b00, 2'b00);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            expect3("midcnt_wait", 2'b00, 2'b00, 2'b00);
        end
        tick();
        expect3("midcnt_rise", 2'b01, 2'b01, 2'b00);
        tick();
        expect3("midcnt_hold", 2'b01, 2'b00, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/input_debounce.md
Name: input_debounce

Overview:
- Upstream conditioning stage for raw asynchronous level inputs (switches, buttons, testbench stimulus) before they reach gate-level logic stages.
- Each channel gets a 2-flop synchronizer, then a saturating-count debounce filter.
- Outputs are glitch-free registered levels plus one-cycle rise/fall pulses; channels are fully independent.

Parameters:
- NUM_CH, 2, number of independent input channels (>=1).
- DEBOUNCE_CYCLES, 4, consecutive stable synchronized cycles required before an output level change (>=1).
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), derived debounce counter width; never less than 1; not overridden by users.

Ports:
- clock  input  1  single system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- din    input  NUM_CH  raw asynchronous levels.
- dout   output NUM_CH  debounced registered levels.
- rise   output NUM_CH  one-cycle pulse, asserted on the cycle dout[i] goes 0->1.
- fall   output NUM_CH  one-cycle pulse, asserted on the cycle dout[i] goes 1->0.

Behaviour:
- Reset: while reset=1, the following are 0 asynchronously: sync1, sync2, all counters, dout, rise and fall. Operation resumes on the first rising edge after reset falls.
- Synchronizer, per channel i, every edge: sync1[i]<=din[i]; sync2[i]<=sync1[i]. No logic between the two flops.
- Filter, per channel, evaluated each edge:
  - sync2==dout: counter<=0; rise, fall <=0.
  - sync2!=dout and counter<DEBOUNCE_CYCLES-1: counter<=counter+1; rise, fall <=0.
  - sync2!=dout and counter==DEBOUNCE_CYCLES-1: dout<=sync2; counter<=0; rise<=sync2; fall<=~sync2.
- States per channel: STABLE (counter=0, sync2==dout) and PENDING (sync2!=dout, counting).
  - PENDING->STABLE on either an input revert (counter cleared, no output change) or terminal count (output toggles).
- Latency: a clean step on din captured at edge E changes dout at edge E+1+DEBOUNCE_CYCLES. For the default value of 4, that is edge E+5.
- rise/fall timing: asserted on the same edge dout changes, and deasserted on the next edge. rise and fall are never both 1 on a channel.
- Glitch rejection: a sync2 deviation lasting fewer than DEBOUNCE_CYCLES cycles produces no dout change and no pulse. The counter restarts from 0 on any revert; there is no partial credit.
- DEBOUNCE_CYCLES=1: dout follows sync2 one edge later; this is pure 3-flop synchronization.
- Counter never exceeds DEBOUNCE_CYCLES-1, so there is no wrap-around.
- Channels share no state. Simultaneous changes on several channels are processed independently in the same cycle.
- Reset mid-PENDING: the count is discarded and dout returns to 0. If din is held 1 through reset, dout rises again 2+DEBOUNCE_CYCLES edges after release (first edge samples into sync1), with a rise pulse.
- No combinational path from din to any output.

Decomposition:
- No shared package needed.
- DEBOUNCE_CYCLES and CNT_W are local parameters passed down.
- One natural sub-module, debounce_ch: a single-channel synchronizer, counter and pulse generator, with ports clock, reset, din, dout, rise, fall.
- input_debounce instantiates NUM_CH copies in a generate loop.

Test Plan:
- Reset: assert reset with din=2'b11 for 3 cycles -> dout=0, rise=0, fall=0 throughout, including mid-cycle async assertion.
- Clean step: release reset, then drive din[0] 0->1 and hold (DEBOUNCE_CYCLES=4) -> dout[0]=1 exactly 5 edges after the first sampling edge. rise[0] is high for exactly one cycle on that edge; dout[1] stays 0.
- Glitch: din[1] pulses 1 for 3 cycles, then 0 -> dout[1] stays 0 and rise[1] never asserts. A following pulse of 4 cycles -> dout[1]=1 with one rise[1] pulse, then later 0 with one fall[1] pulse.
- Bounce: din[0] toggles 1,0,1,0,1 on consecutive cycles, then holds 1 -> a single dout[0] 0->1 transition, 5 edges after the final stable sample, with exactly one rise pulse.
- Simultaneous: din=2'b00->2'b11 on the same edge -> both dout bits rise on the same edge and both rise bits pulse together. Then 2'b11->2'b00 -> both fall bits pulse together.
- Reset mid-count: hold din[0]=1, assert reset after 2 counting cycles, release with din[0] still 1 -> dout[0]=0 during reset, then 1 again 6 edges after release.
